tdp_tile_reader: RTL and testbench

Read-side sequencer for the 20480×16 true-dual-port activation/weight buffer. It takes a 2-D tile descriptor (base, row length, row count, row stride) and drives read addresses onto one buffer port. The buffer's combinational read data is captured into a small FIFO and presented to the compute array as a valid/ready stream with row and tile end markers. It sits directly downstream of the buffer, between buffer port B and the PE array input.

---
 rtl/tdp_tile_reader.sv | 153 +++++++++++++++
 tb/tb_tdp_tile_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_tile_reader.sv
// tdp_tile_reader: walks a 2-D tile descriptor over buffer port B and streams the
// read words through a small FIFO. Defining BOUNDS_CHECK_EN adds an address range check.
module tdp_tile_reader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int MEM_DEPTH  = 20480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        row_len,
  input  logic [7:0]        num_rows,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eor,
  output logic              out_eot,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t state, state_nxt;

  logic [7:0]        len_q, rows_q, col, row;
  logic [ADDR_W-1:0] stride_q, row_ptr, addr_q, issue_addr;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic              can_issue, oob, push, pop, last_col, last_row;

  // Issue is gated only by the registered FIFO count, keeping out_ready off the address path.
  assign can_issue = (state == ISSUE) && (count < CNT_W'(FIFO_DEPTH));
  assign last_col  = (col == len_q - 8'd1);
  assign last_row  = (row == rows_q - 8'd1);

`ifdef BOUNDS_CHECK_EN
  logic [ADDR_W:0] addr_wide;
  logic            err_q;

  assign addr_wide  = {1'b0, row_ptr} + (ADDR_W+1)'(col);
  assign issue_addr = addr_wide[ADDR_W-1:0];
  assign oob        = addr_wide >= (ADDR_W+1)'(MEM_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_q <= 1'b0;
    else if (state == IDLE && start) err_q <= 1'b0;
    else if (can_issue && oob)     err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign issue_addr = row_ptr + ADDR_W'(col);
  assign oob        = 1'b0;
  assign err        = 1'b0;
`endif

  assign push = can_issue && !oob;
  assign pop  = (count != '0) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // An empty tile passes through DRAIN for one cycle so its done pulse lands two cycles after start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (row_len == 8'd0 || num_rows == 8'd0) state_nxt = DRAIN;
          else                                     state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (can_issue && oob)                    state_nxt = DRAIN;
        else if (push && last_col && last_row)   state_nxt = DRAIN;
      end
      DRAIN: begin
        if (count == '0 || (count == CNT_W'(1) && pop)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      rows_q   <= '0;
      stride_q <= '0;
      row_ptr  <= '0;
      col      <= '0;
      row      <= '0;
      addr_q   <= '0;
    end else if (state == IDLE && start) begin
      len_q    <= row_len;
      rows_q   <= num_rows;
      stride_q <= row_stride;
      row_ptr  <= base_addr;
      col      <= '0;
      row      <= '0;
    end else if (push) begin
      addr_q <= issue_addr;
      if (last_col) begin
        col     <= '0;
        row     <= row + 8'd1;
        row_ptr <= row_ptr + stride_q;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {mem_rdata, last_col, last_col && last_row};
  end

  // Head fields are forced to zero while empty so the stream reads clean after reset.
  assign out_valid                    = (count != '0);
  assign {out_data, out_eor, out_eot} = out_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_ren                      = push;
  assign mem_addr                     = push ? issue_addr : addr_q;
  assign busy                         = (state != IDLE);
  assign done                         = (state == FIN);
endmodule

// File: tb/tb_tdp_tile_reader.sv
// tb_tdp_tile_reader: randomized and directed tiles checked every cycle against a
// descriptor-level model (address list, word queue, FIFO occupancy arithmetic).
module tb_tdp_tile_reader;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 15;
  localparam int MEM_DEPTH  = 20480;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [7:0]        row_len = '0;
  logic [7:0]        num_rows = '0;
  logic [ADDR_W-1:0] row_stride = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_eor, out_eot, busy, done, err;

  tdp_tile_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .row_len(row_len),
    .num_rows(num_rows), .row_stride(row_stride), .mem_addr(mem_addr), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eor(out_eor), .out_eot(out_eot), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return (16'(a) * 16'd40503) ^ 16'hA5C3;
  endfunction

  assign mem_rdata = memf(mem_addr);

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int ready_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready: 0 = held low, 1 = held high, otherwise random per cycle
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      out_ready = 1'b0;
    else if (ready_mode == 1) out_ready = 1'b1;
    else                      out_ready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model state
  bit                active = 1'b0;
  bit                abort_tile = 1'b0;
  int                done_at = -1;
  int                issued = 0, popped = 0, total = 0;
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W+1:0] exp_word[$];
  logic [ADDR_W-1:0] last_addr = '0;

  // Observation logs for the directed pins
  logic [ADDR_W-1:0] log_addr[$];
  int ren_count = 0, hs_count = 0, done_count = 0, busy_count = 0, eor_mask = 0, eot_mask = 0;

  int  occ;
  bit  ren_exp, done_now, accept;

  task automatic buildTile(input int base, input int len, input int rows, input int stride);
    int rp, a;
    exp_addr.delete();
    exp_word.delete();
    abort_tile = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < len; c++) begin
        rp = (base + r * stride) % 32768;
        a  = rp + c;
`ifdef BOUNDS_CHECK_EN
        if (a >= MEM_DEPTH) abort_tile = 1'b1;
`endif
        if (!abort_tile) begin
          exp_addr.push_back(ADDR_W'(a % 32768));
          exp_word.push_back({memf(ADDR_W'(a % 32768)), 1'(c == len - 1), 1'(c == len - 1 && r == rows - 1)});
        end
      end
    end
    total = exp_addr.size();
  endtask

  // Per-cycle compare against the model, sampled on the inactive edge
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0; issued = 0; popped = 0; last_addr = '0; done_at = -1;
    end else begin
      occ     = issued - popped;
      ren_exp = active && (issued < total) && (occ < FIFO_DEPTH);
      checkOutput("mem_ren", mem_ren, ren_exp);
      checkOutput("out_valid", out_valid, occ > 0);
      checkOutput("busy", busy, active);
      if (busy) busy_count++;

      if (!abort_tile) checkOutput("done", done, cyc == done_at);
      else if (!(popped == total && issued == total)) checkOutput("done_early", done, 0);
      done_now = abort_tile ? (done && popped == total && issued == total) : (cyc == done_at);
      if (done_now) begin
        done_count++;
        checkOutput("err_at_done", err, abort_tile);
      end

      if (out_valid && popped < total) begin
        checkOutput("out_data", out_data, exp_word[popped][DATA_W+1:2]);
        checkOutput("out_eor", out_eor, exp_word[popped][1]);
        checkOutput("out_eot", out_eot, exp_word[popped][0]);
      end

      if (mem_ren) begin
        ren_count++;
        log_addr.push_back(mem_addr);
        if (issued < total) begin
          checkOutput("mem_addr", mem_addr, exp_addr[issued]);
          last_addr = exp_addr[issued];
        end
        issued++;
      end else begin
        checkOutput("mem_addr_hold", mem_addr, last_addr);
      end

      if (out_valid && out_ready) begin
        if (out_eor) eor_mask |= (1 << hs_count);
        if (out_eot) eot_mask |= (1 << hs_count);
        hs_count++;
        if (popped < total && exp_word[popped][0]) done_at = cyc + 1;
        popped++;
      end

      accept = start && !active;
      if (done_now) active = 1'b0;
      if (accept) begin
        buildTile(int'(base_addr), int'(row_len), int'(num_rows), int'(row_stride));
        active = 1'b1;
        issued = 0; popped = 0;
        done_at = (row_len == 8'd0 || num_rows == 8'd0) ? cyc + 2 : -1;
        log_addr.delete();
        ren_count = 0; hs_count = 0; done_count = 0; busy_count = 0; eor_mask = 0; eot_mask = 0;
      end
    end
  end

  task automatic applyStimulus(input int base, input int len, input int rows, input int stride);
    @(posedge clk); #1;
    base_addr  = ADDR_W'(base);
    row_len    = 8'(len);
    num_rows   = 8'(rows);
    row_stride = ADDR_W'(stride);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitTile(input int budget);
    int n = 0;
    while (active && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (active) begin
      checks++;
      $display("[TB] FAIL tile_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_ren"}, mem_ren, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_out_eor"}, out_eor, 0);
    checkOutput({tag, "_out_eot"}, out_eot, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  task automatic pinAddrs(input string name, input int lit[$]);
    checkOutput({name, "_count"}, log_addr.size(), lit.size());
    for (int i = 0; i < lit.size(); i++)
      checkOutput(name, (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hFFFF_FFFF, lit[i]);
  endtask

  int lit_q[$];

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    $display("[TB] tdp_tile_reader bench start");
    repeat (3) @(posedge clk);
    #1 checkReset("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // Basic 3x2 tile, consumer always ready
    ready_mode = 1;
    applyStimulus(100, 3, 2, 10);
    waitTile(200);
    lit_q = '{100, 101, 102, 110, 111, 112};
    pinAddrs("t1_addr", lit_q);
    checkOutput("t1_eor_mask", eor_mask, 36);
    checkOutput("t1_eot_mask", eot_mask, 32);
    checkOutput("t1_done_count", done_count, 1);

    // Same tile with the consumer stalled for 10 cycles
    ready_mode = 0;
    applyStimulus(100, 3, 2, 10);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t2_ren_during_stall", ren_count, 4);
    checkOutput("t2_valid_stall", out_valid, 1);
    checkOutput("t2_head_stall", out_data, memf(15'd100));
    ready_mode = 1;
    waitTile(200);
    checkOutput("t2_words", hs_count, 6);
    checkOutput("t2_done_count", done_count, 1);

    // Empty tile
    applyStimulus(0, 0, 5, 1);
    waitTile(50);
    checkOutput("t3_ren", ren_count, 0);
    checkOutput("t3_words", hs_count, 0);
    checkOutput("t3_busy_cycles", busy_count, 2);
    checkOutput("t3_done_count", done_count, 1);

    // Start pulsed again mid-tile must be ignored
    applyStimulus(100, 3, 2, 10);
    @(posedge clk);
    applyStimulus(500, 2, 2, 7);
    waitTile(200);
    lit_q = '{100, 101, 102, 110, 111, 112};
    pinAddrs("t4_addr", lit_q);
    checkOutput("t4_done_count", done_count, 1);

    // Asynchronous reset after three words
    applyStimulus(100, 3, 2, 10);
    n = 0;
    while (hs_count < 3 && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("t5_words_before_reset", hs_count, 3);
    #2 rst_n = 1'b0;
    #1 checkReset("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    checkOutput("t5_no_done", done_count, 0);
    applyStimulus(200, 2, 3, 5);
    waitTile(200);
    lit_q = '{200, 201, 205, 206, 210, 211};
    pinAddrs("t5_addr", lit_q);

    // Tile that runs past the end of the buffer
    applyStimulus(20478, 4, 1, 0);
    waitTile(200);
`ifdef BOUNDS_CHECK_EN
    lit_q = '{20478, 20479};
    pinAddrs("t6_addr", lit_q);
    checkOutput("t6_words", hs_count, 2);
    checkOutput("t6_eot_mask", eot_mask, 0);
    checkOutput("t6_err", err, 1);
`else
    lit_q = '{20478, 20479, 20480, 20481};
    pinAddrs("t6_addr", lit_q);
    checkOutput("t6_eot_mask", eot_mask, 8);
    checkOutput("t6_err", err, 0);
`endif
    checkOutput("t6_done_count", done_count, 1);

    // Randomized tiles with a randomly stalling consumer
    ready_mode = 2;
    for (int t = 0; t < 16; t++) begin
      applyStimulus($urandom_range(0, 32767), $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 32767));
      waitTile(2000);
      checkOutput("rand_done_count", done_count, 1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
